// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staggered multi-domain reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    ASSERT  = 2'd3
  } state_e;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_NDM  = 1;
  localparam int CAUSE_SW   = 2;
  localparam int CAUSE_WDOG = 3;

  typedef logic [3:0] rst_cause_t;

  localparam rst_cause_t CausePor  = rst_cause_t'(1 << CAUSE_POR);
  localparam rst_cause_t CauseNdm  = rst_cause_t'(1 << CAUSE_NDM);
  localparam rst_cause_t CauseSw   = rst_cause_t'(1 << CAUSE_SW);
  localparam rst_cause_t CauseWdog = rst_cause_t'(1 << CAUSE_WDOG);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Synchroniser with asynchronous preset to ResetVal: a reset-deassert
// synchroniser when ResetVal=1/d_i=0, a plain request synchroniser when ResetVal=0.
module rst_sync #(
  parameter int   Stages   = 2,
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[Stages-2:0], d_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {Stages{ResetVal}};
    else       sync_q <= sync_d;
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staggered release of NumDomains reset domains from POR/ndmreset/sw/wdog sources.
// Optional RST_SEQ_REQ_SYNC_EN: synchronise ndmreset and watchdog requests (3-cycle latency).
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int                    NumDomains = 4,
  parameter int                    SyncStages = 2,
  parameter int                    HoldCycles = 8,
  parameter int                    StageGap   = 16,
  parameter logic [NumDomains-1:0] NdmMask    = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ndmreset_req_i,
  input  logic                  sw_rst_req_i,
  input  logic                  wdog_rst_req_i,
  output logic [NumDomains-1:0] rst_no,
  output logic [3:0]            rst_cause_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CntMax = max3(HoldCycles, StageGap, NumDomains);
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(StageGap - 1);
  localparam logic [CntW-1:0] CntSat   = CntW'(CntMax);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDomains - 1);

  logic sys_rst;
  logic ndm_req, wdog_req;

  // rst_i asserts the FSM at once (async preset); release is SyncStages edges late.
  rst_sync #(.Stages(SyncStages), .ResetVal(1'b1)) u_por_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (1'b0),
    .q_o   (sys_rst)
  );

`ifdef RST_SEQ_REQ_SYNC_EN
  logic wdog_s, wdog_dly_q, wdog_dly_d, wdog_prev_q, wdog_prev_d;

  rst_sync #(.Stages(2), .ResetVal(1'b0)) u_ndm_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ndmreset_req_i),
    .q_o   (ndm_req)
  );

  // Two-cycle stretch ahead of the synchroniser, then a rising-edge detect.
  rst_sync #(.Stages(2), .ResetVal(1'b0)) u_wdog_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wdog_rst_req_i | wdog_dly_q),
    .q_o   (wdog_s)
  );

  always_comb begin
    wdog_dly_d  = wdog_rst_req_i;
    wdog_prev_d = wdog_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_dly_q  <= 1'b0;
      wdog_prev_q <= 1'b0;
    end else begin
      wdog_dly_q  <= wdog_dly_d;
      wdog_prev_q <= wdog_prev_d;
    end
  end

  assign wdog_req = wdog_s & ~wdog_prev_q;
`else
  assign ndm_req  = ndmreset_req_i;
  assign wdog_req = wdog_rst_req_i;
`endif

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]         idx_q, idx_d, rel_idx;
  logic                    rel_en, do_assert;
  logic [NumDomains-1:0]   rst_n_q, rst_n_d, amask;
  rst_cause_t              cause_q, cause_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_n_d   = rst_n_q;
    cause_d   = cause_q;
    done_d    = 1'b0;
    rel_en    = 1'b0;
    rel_idx   = '0;
    do_assert = 1'b0;
    amask     = '1;
    cnt_inc   = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);

    // Watchdog always wins and hits every domain; sw only acts from RUN.
    if (wdog_req) begin
      do_assert = 1'b1;
      cause_d   = CauseWdog;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ndm_req) begin
            do_assert = 1'b1;
            amask     = NdmMask;
            cause_d   = CauseNdm;
          end else if (sw_rst_req_i) begin
            do_assert = 1'b1;
            amask     = NdmMask;
            cause_d   = CauseSw;
          end
        end
        ASSERT: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          if (ndm_req) begin
            cnt_d   = '0;
            rst_n_d = rst_n_q & ~NdmMask;
            cause_d = CauseNdm;
          end else if (cnt_q == HoldLast) begin
            rel_en = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (ndm_req) begin
            state_d = HOLD;
            cnt_d   = '0;
            rst_n_d = rst_n_q & ~NdmMask;
            cause_d = CauseNdm;
          end else if (cnt_q == GapLast) begin
            rel_en  = 1'b1;
            rel_idx = idx_q + IdxW'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = HOLD;
      endcase
    end

    if (do_assert) begin
      state_d = ASSERT;
      cnt_d   = '0;
      rst_n_d = rst_n_q & ~amask;
    end

    if (rel_en) begin
      rst_n_d[rel_idx] = 1'b1;
      if (rel_idx == IdxLast) begin
        state_d = RUN;
        done_d  = 1'b1;
      end else begin
        state_d = RELEASE;
        idx_d   = rel_idx;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      cause_q <= CausePor;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      cause_q <= cause_d;
      done_q  <= done_d;
    end
  end

  assign rst_no      = rst_n_q;
  assign rst_cause_o = cause_q;
  assign busy_o      = (state_q != RUN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expectations keyed by cycle, checked on negedge.
module tb_rst_seq_ctrl;

  localparam int S = 2;
  localparam int H = 8;
  localparam int G = 16;
`ifdef RST_SEQ_REQ_SYNC_EN
  localparam int WLAT = 3;
  localparam int NLAT = 3;
`else
  localparam int WLAT = 1;
  localparam int NLAT = 1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       ndmreset_req_i = 1'b0;
  logic       sw_rst_req_i = 1'b0;
  logic       wdog_rst_req_i = 1'b0;
  logic [3:0] rst_no;
  logic [3:0] rst_cause_o;
  logic       busy_o;
  logic       done_o;
  logic [9:0] obs;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int         cyc;
    logic [9:0] v;
    string      name;
  } exp_t;
  exp_t sb[$];

  rst_seq_ctrl #(
    .NumDomains (4),
    .SyncStages (S),
    .HoldCycles (H),
    .StageGap   (G),
    .NdmMask    (4'b1110)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ndmreset_req_i (ndmreset_req_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .wdog_rst_req_i (wdog_rst_req_i),
    .rst_no         (rst_no),
    .rst_cause_o    (rst_cause_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  assign obs = {rst_no, rst_cause_o, busy_o, done_o};

  task automatic push(input int c, input logic [9:0] v, input string n);
    exp_t e;
    e.cyc = c; e.v = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    total_cnt++;
    if (obs !== {4'b0000, 4'b0001, 2'b10}) $display("FAIL reset_state got %b want %b", obs, {4'b0000, 4'b0001, 2'b10});
    else pass_cnt++;
    repeat (3) @(negedge clk_i);
    total_cnt++;
    if (obs !== {4'b0000, 4'b0001, 2'b10}) $display("FAIL reset_held got %b want %b", obs, {4'b0000, 4'b0001, 2'b10});
    else pass_cnt++;
  endtask

  task automatic test_por(input string tag);
    int c0, r, g;
    exp_t e;
    @(negedge clk_i);
    c0 = cyc; rst_i = 1'b0;
    r = c0 + S + H;
    push(c0 + 1,     {4'b0000, 4'b0001, 2'b10}, "hold_start");
    push(r - 1,      {4'b0000, 4'b0001, 2'b10}, "hold_end");
    push(r,          {4'b0001, 4'b0001, 2'b10}, "dom0");
    push(r + G - 1,  {4'b0001, 4'b0001, 2'b10}, "dom1_pre");
    push(r + G,      {4'b0011, 4'b0001, 2'b10}, "dom1");
    push(r + 2*G,    {4'b0111, 4'b0001, 2'b10}, "dom2");
    push(r + 3*G - 1,{4'b0111, 4'b0001, 2'b10}, "dom3_pre");
    push(r + 3*G,    {4'b1111, 4'b0001, 2'b01}, "dom3_done");
    push(r + 3*G + 1,{4'b1111, 4'b0001, 2'b00}, "run");
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk_i); g++;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); total_cnt++;
        if (obs !== e.v || e.cyc != cyc) $display("FAIL %s_%s cyc %0d got %b want %b", tag, e.name, cyc, obs, e.v);
        else pass_cnt++;
      end
    end
    if (sb.size() != 0) begin total_cnt++; $display("FAIL %s_timeout pending %0d want 0", tag, sb.size()); sb.delete(); end
  endtask

  task automatic test_ndm();
    int c0, d, r, g;
    bit d0_low;
    exp_t e;
    @(negedge clk_i);
    c0 = cyc; ndmreset_req_i = 1'b1; d0_low = 0;
    d = c0 + 20 + NLAT - 1;
    r = d + H;
    push(c0 + NLAT,     {4'b0001, 4'b0010, 2'b10}, "assert");
    push(c0 + NLAT + 1, {4'b0001, 4'b0010, 2'b10}, "hold");
    push(d,             {4'b0001, 4'b0010, 2'b10}, "drop");
    push(r - 1,         {4'b0001, 4'b0010, 2'b10}, "hold_end");
    push(r,             {4'b0001, 4'b0010, 2'b10}, "slot0");
    push(r + G - 1,     {4'b0001, 4'b0010, 2'b10}, "dom1_pre");
    push(r + G,         {4'b0011, 4'b0010, 2'b10}, "dom1");
    push(r + 2*G,       {4'b0111, 4'b0010, 2'b10}, "dom2");
    push(r + 3*G,       {4'b1111, 4'b0010, 2'b01}, "done");
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk_i); g++;
      if (rst_no[0] !== 1'b1) d0_low = 1;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); total_cnt++;
        if (obs !== e.v || e.cyc != cyc) $display("FAIL ndm_%s cyc %0d got %b want %b", e.name, cyc, obs, e.v);
        else pass_cnt++;
      end
      ndmreset_req_i = (cyc < c0 + 20);
    end
    ndmreset_req_i = 1'b0;
    if (sb.size() != 0) begin total_cnt++; $display("FAIL ndm_timeout pending %0d want 0", sb.size()); sb.delete(); end
    total_cnt++;
    if (d0_low) $display("FAIL ndm_dom0_untouched got asserted want released");
    else pass_cnt++;
  endtask

  task automatic test_sw_wdog_same();
    int c0, w, r, g;
    exp_t e;
    @(negedge clk_i);
    c0 = cyc; sw_rst_req_i = 1'b1; wdog_rst_req_i = 1'b1;
    w = c0 + WLAT;
    r = w + 1 + H;
    push(w,       {4'b0000, 4'b1000, 2'b10}, "all_low");
    push(r - 1,   {4'b0000, 4'b1000, 2'b10}, "hold_end");
    push(r,       {4'b0001, 4'b1000, 2'b10}, "dom0");
    push(r + 3*G, {4'b1111, 4'b1000, 2'b01}, "done");
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk_i); g++;
      sw_rst_req_i = 1'b0; wdog_rst_req_i = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); total_cnt++;
        if (obs !== e.v || e.cyc != cyc) $display("FAIL swwdog_%s cyc %0d got %b want %b", e.name, cyc, obs, e.v);
        else pass_cnt++;
      end
    end
    if (sb.size() != 0) begin total_cnt++; $display("FAIL swwdog_timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_sw_release();
    int c0, r, g;
    exp_t e;
    @(negedge clk_i);
    c0 = cyc; sw_rst_req_i = 1'b1;
    r = c0 + 2 + H;
    push(c0 + 1,      {4'b0001, 4'b0100, 2'b10}, "assert");
    push(r - 1,       {4'b0001, 4'b0100, 2'b10}, "hold_end");
    push(r + G,       {4'b0011, 4'b0100, 2'b10}, "dom1");
    push(r + 2*G,     {4'b0111, 4'b0100, 2'b10}, "dom2");
    push(r + 2*G + 4, {4'b0111, 4'b0100, 2'b10}, "ignored");
    push(r + 3*G - 1, {4'b0111, 4'b0100, 2'b10}, "dom3_pre");
    push(r + 3*G,     {4'b1111, 4'b0100, 2'b01}, "done");
    push(r + 3*G + 1, {4'b1111, 4'b0100, 2'b00}, "run");
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk_i); g++;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); total_cnt++;
        if (obs !== e.v || e.cyc != cyc) $display("FAIL swrel_%s cyc %0d got %b want %b", e.name, cyc, obs, e.v);
        else pass_cnt++;
      end
      sw_rst_req_i = (cyc == r + 2*G + 2);
    end
    sw_rst_req_i = 1'b0;
    if (sb.size() != 0) begin total_cnt++; $display("FAIL swrel_timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_wdog_release();
    int c0, r, w, r2, g;
    exp_t e;
    @(negedge clk_i);
    c0 = cyc; sw_rst_req_i = 1'b1;
    r = c0 + 2 + H;
    w = r + 2*G + 3 + WLAT - 1;
    r2 = w + 1 + H;
    push(r + 2*G,      {4'b0111, 4'b0100, 2'b10}, "dom2");
    push(w - 1,        {4'b0111, 4'b0100, 2'b10}, "pre_bite");
    push(w,            {4'b0000, 4'b1000, 2'b10}, "bite");
    push(r2 - 1,       {4'b0000, 4'b1000, 2'b10}, "hold_end");
    push(r2,           {4'b0001, 4'b1000, 2'b10}, "dom0");
    push(r2 + G,       {4'b0011, 4'b1000, 2'b10}, "dom1");
    push(r2 + 2*G,     {4'b0111, 4'b1000, 2'b10}, "dom2b");
    push(r2 + 3*G,     {4'b1111, 4'b1000, 2'b01}, "done");
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk_i); g++;
      sw_rst_req_i = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); total_cnt++;
        if (obs !== e.v || e.cyc != cyc) $display("FAIL wdogrel_%s cyc %0d got %b want %b", e.name, cyc, obs, e.v);
        else pass_cnt++;
      end
      wdog_rst_req_i = (cyc == r + 2*G + 2);
    end
    wdog_rst_req_i = 1'b0;
    if (sb.size() != 0) begin total_cnt++; $display("FAIL wdogrel_timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_rst_mid();
    int c0, r;
    @(negedge clk_i);
    c0 = cyc; sw_rst_req_i = 1'b1;
    r = c0 + 2 + H;
    @(negedge clk_i);
    sw_rst_req_i = 1'b0;
    repeat (r + G + 3 - c0) @(negedge clk_i);
    total_cnt++;
    if (obs !== {4'b0011, 4'b0100, 2'b10}) $display("FAIL rstmid_pre cyc %0d got %b want %b", cyc, obs, {4'b0011, 4'b0100, 2'b10});
    else pass_cnt++;
    #2 rst_i = 1'b1;
    #1;
    total_cnt++;
    if (obs !== {4'b0000, 4'b0001, 2'b10}) $display("FAIL rstmid_async got %b want %b", obs, {4'b0000, 4'b0001, 2'b10});
    else pass_cnt++;
    repeat (2) @(negedge clk_i);
    test_por("repor");
  endtask

  initial begin
    test_reset();
    test_por("por");
    test_ndm();
    test_sw_wdog_same();
    test_sw_release();
    test_wdog_release();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
